// File: rtl/imem_port_arbiter.sv
// Instruction-memory port arbiter: shares one single-port SRAM between a
// fetch read stream (with a small response FIFO) and a program-load writer.
// Requests are granted round-robin. A read's data is returned one cycle after
// its grant and queued in order.
module imem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RSP_DEPTH  = 2
) (
  input  logic                  clk0,
  input  logic                  rst,
  input  logic                  fetch_req_valid,
  output logic                  fetch_req_ready,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_rsp_valid,
  input  logic                  fetch_rsp_ready,
  output logic [DATA_WIDTH-1:0] fetch_rsp_data,
  input  logic                  fetch_flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam int unsigned PtrW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned OccW = CntW + 1;

  typedef enum logic {
    GrantRead  = 1'b0,
    GrantWrite = 1'b1
  } grant_e;

  logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  inflight_q, inflight_d;
  grant_e                last_grant_q, last_grant_d;

  logic            pop, push;
  logic            rd_elig, wr_elig;
  logic            grant_rd, grant_wr;
  logic [OccW-1:0] occupancy;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RSP_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // FIFO head status, eligibility and round-robin grant selection.
  always_comb begin
    fetch_rsp_valid = ~rst & (count_q != '0);
    fetch_rsp_data  = fifo_q[rd_ptr_q];
    pop             = fetch_rsp_valid & fetch_rsp_ready;
    // A slot is needed for every read already queued or still in the SRAM.
    occupancy       = OccW'(count_q) + OccW'(inflight_q);
    rd_elig         = ~rst & fetch_req_valid & ~fetch_flush &
                      (occupancy < OccW'(RSP_DEPTH) + OccW'(pop));
    wr_elig         = ~rst & wr_valid;
    grant_rd        = 1'b0;
    grant_wr        = 1'b0;
    if (rd_elig && wr_elig) begin
      if (last_grant_q == GrantWrite) grant_rd = 1'b1;
      else                            grant_wr = 1'b1;
    end else begin
      grant_rd = rd_elig;
      grant_wr = wr_elig;
    end
  end

  // SRAM command and handshake outputs, idle unless a grant is made.
  always_comb begin
    sram_csb0       = 1'b1;
    sram_web0       = 1'b1;
    sram_addr0      = '0;
    sram_din0       = '0;
    fetch_req_ready = grant_rd;
    wr_ready        = grant_wr;
    if (grant_rd) begin
      sram_csb0  = 1'b0;
      sram_addr0 = fetch_addr;
    end else if (grant_wr) begin
      sram_csb0  = 1'b0;
      sram_web0  = 1'b0;
      sram_addr0 = wr_addr;
      sram_din0  = wr_data;
    end
  end

  // Next-state for FIFO pointers/count, in-flight flag and arbitration history.
  always_comb begin
    // Read data lands this edge unless a flush discards it.
    push         = inflight_q & ~fetch_flush & ~rst;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    inflight_d   = grant_rd;
    last_grant_d = last_grant_q;
    if (grant_rd)      last_grant_d = GrantRead;
    else if (grant_wr) last_grant_d = GrantWrite;
    if (fetch_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + CntW'(1);
      else if (!push && pop) count_d = count_q - CntW'(1);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk0) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      inflight_q   <= 1'b0;
      last_grant_q <= GrantWrite;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Response storage; contents are meaningless while the count says empty.
  always_ff @(posedge clk0) begin
    if (push) fifo_q[wr_ptr_q] <= sram_dout0;
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural 1-cycle SRAM.
module tb_imem_port_arbiter;

  logic        clk0 = 1'b0;
  logic        rst;
  logic        fetch_req_valid, fetch_req_ready;
  logic [7:0]  fetch_addr;
  logic        fetch_rsp_valid, fetch_rsp_ready;
  logic [31:0] fetch_rsp_data;
  logic        fetch_flush;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        sram_csb0, sram_web0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0, sram_dout0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk0 = ~clk0;

  imem_port_arbiter #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .RSP_DEPTH (2)
  ) dut (
    .clk0           (clk0),
    .rst            (rst),
    .fetch_req_valid(fetch_req_valid),
    .fetch_req_ready(fetch_req_ready),
    .fetch_addr     (fetch_addr),
    .fetch_rsp_valid(fetch_rsp_valid),
    .fetch_rsp_ready(fetch_rsp_ready),
    .fetch_rsp_data (fetch_rsp_data),
    .fetch_flush    (fetch_flush),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .sram_csb0      (sram_csb0),
    .sram_web0      (sram_web0),
    .sram_addr0     (sram_addr0),
    .sram_din0      (sram_din0),
    .sram_dout0     (sram_dout0)
  );

  // SRAM model: preloaded with 0x1000+addr while rst is high.
  logic [31:0] mem [256];
  always @(posedge clk0) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000 + i;
    end else if (!sram_csb0) begin
      if (!sram_web0) mem[sram_addr0] <= sram_din0;
      else            sram_dout0 <= mem[sram_addr0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req_ready"}, {31'd0, fetch_req_ready}, 32'd0);
    chk({tag, " wr_ready"},  {31'd0, wr_ready},        32'd0);
    chk({tag, " rsp_valid"}, {31'd0, fetch_rsp_valid}, 32'd0);
    chk({tag, " csb0"},      {31'd0, sram_csb0},       32'd1);
    chk({tag, " web0"},      {31'd0, sram_web0},       32'd1);
    chk({tag, " addr0"},     {24'd0, sram_addr0},      32'd0);
    chk({tag, " din0"},      sram_din0,                32'd0);
  endtask

  task automatic idle_inputs();
    fetch_req_valid = 1'b0;
    fetch_addr      = '0;
    fetch_rsp_ready = 1'b0;
    fetch_flush     = 1'b0;
    wr_valid        = 1'b0;
    wr_addr         = '0;
    wr_data         = '0;
  endtask

  initial begin
    // Reset with every request asserted: nothing may be granted.
    rst = 1'b1;
    idle_inputs();
    fetch_req_valid = 1'b1;
    fetch_addr      = 8'h33;
    wr_valid        = 1'b1;
    wr_addr         = 8'h44;
    wr_data         = 32'hDEAD_BEEF;
    tick();
    settle();
    chk_reset_outputs("reset");
    tick();

    // Write 0xAA to 0x05, then read it back.
    rst = 1'b0;
    idle_inputs();
    wr_valid = 1'b1;
    wr_addr  = 8'h05;
    wr_data  = 32'h0000_00AA;
    settle();
    chk("wb c0 wr_ready", {31'd0, wr_ready},  32'd1);
    chk("wb c0 csb0",     {31'd0, sram_csb0}, 32'd0);
    chk("wb c0 web0",     {31'd0, sram_web0}, 32'd0);
    chk("wb c0 addr0",    {24'd0, sram_addr0}, 32'h05);
    chk("wb c0 din0",     sram_din0,          32'h0000_00AA);
    tick();
    idle_inputs();
    fetch_req_valid = 1'b1;
    fetch_addr      = 8'h05;
    settle();
    chk("wb c1 req_ready", {31'd0, fetch_req_ready}, 32'd1);
    chk("wb c1 csb0",      {31'd0, sram_csb0},       32'd0);
    chk("wb c1 web0",      {31'd0, sram_web0},       32'd1);
    chk("wb c1 addr0",     {24'd0, sram_addr0},      32'h05);
    tick();
    idle_inputs();
    settle();
    chk("wb c2 rsp_valid", {31'd0, fetch_rsp_valid}, 32'd0);
    chk("idle csb0",       {31'd0, sram_csb0},       32'd1);
    chk("idle addr0",      {24'd0, sram_addr0},      32'd0);
    tick();
    fetch_rsp_ready = 1'b1;
    settle();
    chk("wb c3 rsp_valid", {31'd0, fetch_rsp_valid}, 32'd1);
    chk("wb c3 rsp_data",  fetch_rsp_data,           32'h0000_00AA);
    tick();
    settle();
    chk("wb c4 rsp_valid", {31'd0, fetch_rsp_valid}, 32'd0);

    // Four back-to-back reads with the consumer always ready.
    for (int i = 0; i < 7; i++) begin
      fetch_req_valid = (i < 4);
      fetch_addr      = 8'(i);
      fetch_rsp_ready = 1'b1;
      settle();
      if (i < 4) chk($sformatf("b2b req_ready %0d", i), {31'd0, fetch_req_ready}, 32'd1);
      if (i >= 2 && i < 6) begin
        chk($sformatf("b2b rsp_valid %0d", i), {31'd0, fetch_rsp_valid}, 32'd1);
        chk($sformatf("b2b rsp_data %0d", i),  fetch_rsp_data, 32'h1000 + 32'(i - 2));
      end
      if (i == 6) chk("b2b drained", {31'd0, fetch_rsp_valid}, 32'd0);
      tick();
    end

    // Back-pressure: two reads fill the FIFO, then one pop frees one slot.
    idle_inputs();
    fetch_req_valid = 1'b1;
    fetch_addr      = 8'h10;
    settle();
    chk("bp d0 req_ready", {31'd0, fetch_req_ready}, 32'd1);
    tick();
    fetch_addr = 8'h11;
    settle();
    chk("bp d1 req_ready", {31'd0, fetch_req_ready}, 32'd1);
    tick();
    fetch_addr = 8'h12;
    settle();
    chk("bp d2 req_ready", {31'd0, fetch_req_ready}, 32'd0);
    tick();
    settle();
    chk("bp d3 req_ready", {31'd0, fetch_req_ready}, 32'd0);
    chk("bp d3 rsp_valid", {31'd0, fetch_rsp_valid}, 32'd1);
    tick();
    fetch_rsp_ready = 1'b1;
    settle();
    chk("bp d4 rsp_data",  fetch_rsp_data,           32'h1010);
    chk("bp d4 req_ready", {31'd0, fetch_req_ready}, 32'd1);
    tick();
    idle_inputs();
    settle();
    chk("bp d5 rsp_data", fetch_rsp_data, 32'h1011);
    tick();
    fetch_rsp_ready = 1'b1;
    settle();
    chk("bp d6 rsp_data", fetch_rsp_data, 32'h1011);
    tick();
    settle();
    chk("bp d7 rsp_data", fetch_rsp_data, 32'h1012);
    tick();
    settle();
    chk("bp d8 rsp_valid", {31'd0, fetch_rsp_valid}, 32'd0);
    tick();

    // Fresh reset, then both classes contend: R,W,R,W,R,W.
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      fetch_req_valid = 1'b1;
      fetch_addr      = 8'h20;
      fetch_rsp_ready = 1'b1;
      wr_valid        = 1'b1;
      wr_addr         = 8'h30;
      wr_data         = 32'(i);
      settle();
      chk($sformatf("rr %0d req_ready", i), {31'd0, fetch_req_ready}, 32'((i % 2) == 0));
      chk($sformatf("rr %0d wr_ready", i),  {31'd0, wr_ready},        32'((i % 2) == 1));
      if ((i % 2) == 1) chk($sformatf("rr %0d din0", i), sram_din0, 32'(i));
      tick();
    end
    idle_inputs();
    fetch_rsp_ready = 1'b1;
    tick();
    tick();
    settle();
    chk("rr drained", {31'd0, fetch_rsp_valid}, 32'd0);

    // Flush with one entry queued and one read in flight; a write still goes.
    idle_inputs();
    fetch_req_valid = 1'b1;
    fetch_addr      = 8'h40;
    tick();
    fetch_addr = 8'h41;
    settle();
    chk("fl f1 req_ready", {31'd0, fetch_req_ready}, 32'd1);
    tick();
    fetch_flush = 1'b1;
    fetch_addr  = 8'h42;
    wr_valid    = 1'b1;
    wr_addr     = 8'h50;
    wr_data     = 32'h0000_0055;
    settle();
    chk("fl f2 rsp_valid", {31'd0, fetch_rsp_valid}, 32'd1);
    chk("fl f2 req_ready", {31'd0, fetch_req_ready}, 32'd0);
    chk("fl f2 wr_ready",  {31'd0, wr_ready},        32'd1);
    tick();
    idle_inputs();
    settle();
    chk("fl f3 rsp_valid", {31'd0, fetch_rsp_valid}, 32'd0);
    tick();
    settle();
    chk("fl f4 rsp_valid", {31'd0, fetch_rsp_valid}, 32'd0);
    fetch_req_valid = 1'b1;
    fetch_addr      = 8'h50;
    fetch_rsp_ready = 1'b1;
    settle();
    chk("fl f4 req_ready", {31'd0, fetch_req_ready}, 32'd1);
    tick();
    idle_inputs();
    fetch_rsp_ready = 1'b1;
    tick();
    settle();
    chk("fl f6 rsp_valid", {31'd0, fetch_rsp_valid}, 32'd1);
    chk("fl f6 rsp_data",  fetch_rsp_data,           32'h0000_0055);
    tick();

    // Reset the cycle after a read grant: its data must never surface.
    idle_inputs();
    fetch_req_valid = 1'b1;
    fetch_addr      = 8'h60;
    settle();
    chk("rs g0 req_ready", {31'd0, fetch_req_ready}, 32'd1);
    tick();
    rst      = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 8'h61;
    wr_data  = 32'h1234_5678;
    settle();
    chk_reset_outputs("rs g1");
    tick();
    rst = 1'b0;
    idle_inputs();
    fetch_rsp_ready = 1'b0;
    settle();
    chk("rs g2 rsp_valid", {31'd0, fetch_rsp_valid}, 32'd0);
    chk("rs g2 csb0",      {31'd0, sram_csb0},       32'd1);
    tick();
    settle();
    chk("rs g3 rsp_valid", {31'd0, fetch_rsp_valid}, 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 8, SRAM word address width; DATA_WIDTH, 32, SRAM word width; RSP_DEPTH, 2, fetch response FIFO entries.
REQ-002 Ports SHALL be, in order:
- clk0  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req_valid  in  1  fetch read request.
- fetch_req_ready  out  1  read accepted this cycle.
- fetch_addr  in  ADDR_WIDTH  read word address.
- fetch_rsp_valid  out  1  response FIFO head valid.
- fetch_rsp_ready  in  1  consumer pops the head.
- fetch_rsp_data  out  DATA_WIDTH  response FIFO head data.
- fetch_flush  in  1  discard all pending fetch data.
- wr_valid  in  1  program-load write request.
- wr_ready  out  1  write accepted this cycle.
- wr_addr  in  ADDR_WIDTH  write word address.
- wr_data  in  DATA_WIDTH  write data.
- sram_csb0  out  1  SRAM chip select, active low.
- sram_web0  out  1  SRAM write enable, active low.
- sram_addr0  out  ADDR_WIDTH  SRAM address.
- sram_din0  out  DATA_WIDTH  SRAM write data.
- sram_dout0  in  DATA_WIDTH  SRAM read data.

Function
REQ-003 The block SHALL issue at most one SRAM operation per cycle; sram_* outputs are combinational from the current cycle's grant, sampled by the SRAM at the next clk0 rising edge.
REQ-004 Idle cycle: sram_csb0=1, sram_web0=1, sram_addr0 and sram_din0 = 0.
REQ-005 Read grant: sram_csb0=0, sram_web0=1, sram_addr0=fetch_addr, fetch_req_ready=1; write grant: sram_csb0=0, sram_web0=0, sram_addr0=wr_addr, sram_din0=wr_data, wr_ready=1.
REQ-006 Read latency SHALL be 1: a read granted in cycle N has sram_dout0 sampled at the rising edge ending cycle N+1 and pushed into the response FIFO, visible on fetch_rsp_* from cycle N+2 if the FIFO was empty.
REQ-007 A one-bit inflight flag SHALL track a read issued the previous cycle.
REQ-008 A read SHALL be eligible only if fetch_req_valid=1, fetch_flush=0, and fifo_count + inflight - pop < RSP_DEPTH, where pop = fetch_rsp_valid & fetch_rsp_ready.
REQ-009 A write SHALL be eligible whenever wr_valid=1, independent of FIFO state and fetch_flush.
REQ-010 Arbitration SHALL be round-robin via a last_grant bit: when both are eligible, grant the class not granted last; last_grant updates only on a grant.
REQ-011 Response FIFO SHALL be RSP_DEPTH entries, in order; fetch_rsp_data = head entry; push and pop in the same cycle SHALL leave count unchanged; push never occurs when full (guaranteed by REQ-008).
REQ-012 fetch_flush=1 SHALL empty the FIFO at the next edge, clear inflight without pushing its data, and block read grants that cycle; a write may still be granted.
REQ-013 A read and a write to the same address SHALL complete in grant order; no forwarding.
REQ-014 Back-to-back reads with fetch_rsp_ready held 1 SHALL sustain one read per cycle.
REQ-015 fetch_rsp_valid SHALL be 0 when the FIFO is empty; fetch_rsp_data is don't-care then.

Reset
REQ-016 While rst=1: FIFO empty, inflight=0, last_grant=write (read wins the first tie), fetch_req_ready=0, wr_ready=0, fetch_rsp_valid=0, sram_csb0=1, sram_web0=1, sram_addr0=0, sram_din0=0.
REQ-017 Reset asserted with a read in flight SHALL discard that read's data; no push occurs at the reset edge.
REQ-018 First grant possible in the first cycle with rst=0.

Verification
REQ-019 Write 0x0000_00AA at address 0x05, then read 0x05 -> write granted cycle 0 (csb0=0, web0=0); read granted cycle 1; fetch_rsp_valid=1 with data 0x0000_00AA in cycle 3.
REQ-020 Reads 0x00..0x03 with fetch_rsp_ready=1 -> fetch_req_ready=1 four consecutive cycles; responses in address order on four consecutive cycles.
REQ-021 fetch_rsp_ready=0, continuous reads -> exactly 2 reads accepted, then fetch_req_ready=0 until a pop; after one pop, one more read accepted.
REQ-022 wr_valid and fetch_req_valid held high 6 cycles after reset, FIFO always popped -> grants alternate R,W,R,W,R,W.
REQ-023 Read issued cycle N, fetch_flush=1 in cycle N+1 with FIFO holding 1 entry -> FIFO empty and fetch_rsp_valid=0 in cycle N+2; in-flight data never appears.
REQ-024 rst=1 in the cycle after a read grant -> all outputs at REQ-016 values; fetch_rsp_valid stays 0 after reset release.
